fsm_seq_ctrl: RTL and testbench
===============================

Name: fsm_seq_ctrl

Overview:
- Sequencer for the 8-state x/y control FSM: loads an x bit-pattern, clears the FSM to S0, and drives x one bit per clock.
- Logs the FSM's Mealy output y for every step, counts y==1 hits, and compares the final state against a requested target.
- Sits between a test/command source and the FSM; owns the FSM's x input and its synchronous clear for the duration of a run.

Parameters:
- LEN, 8, maximum pattern length in steps (bits of pat / y_log)
- CW, $clog2(LEN+1), width of len and hit_cnt

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- abort  in  1  cancel current run
- pat  in  LEN  x pattern; bit i drives step i
- len  in  CW  number of steps, 1..LEN
- target  in  3  expected final FSM state
- y_in  in  1  FSM y output (combinational from state and x_out)
- state_in  in  3  FSM current state
- x_out  out  1  x drive to FSM
- fsm_clr  out  1  synchronous clear-to-S0 request to FSM
- busy  out  1  high in CLEAR/RUN/DONE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on illegal start
- y_log  out  LEN  captured y, bit i = y at step i
- hit_cnt  out  CW  number of steps with y==1
- final_state  out  3  state_in captured in DONE
- match  out  1  final_state == latched target

Behaviour:
- Reset (reset==0, async): state IDLE; x_out, fsm_clr, busy, done, err, match = 0; y_log = 0; hit_cnt = 0; final_state = 0; internal step index = 0.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: start==1 and 1<=len<=LEN -> latch pat, len, target; clear y_log, hit_cnt, match; go CLEAR. start==1 with len==0 or len>LEN -> err=1 for one cycle, stay IDLE, results untouched. start==0 -> stay IDLE.
- CLEAR: fsm_clr=1 for exactly this cycle; x_out=0; index=0; go RUN. The FSM is in S0 on the first RUN cycle.
- RUN: x_out = latched pat[index] combinationally from the registered index. At each rising edge: y_log[index] <= y_in, hit_cnt += y_in. If index==len-1, go DONE, otherwise index++.
- DONE (one cycle): x_out=0; done=1; final_state <= state_in; match <= (state_in==latched target); go IDLE.
- Latency: start edge -> done high = len+2 cycles. busy is high for len+2 cycles.
- Outputs y_log, hit_cnt, final_state, and match hold until the next accepted start.
- start while busy: ignored with no err.
- abort in CLEAR or RUN: go IDLE next edge; x_out=0; no done pulse. Partial y_log and hit_cnt are retained; match=0.
- abort in DONE: ignored, so done still pulses. abort and start together in IDLE: start wins and abort is ignored.
- hit_cnt never exceeds len, so it cannot wrap.
- Async reset mid-run: immediate return to IDLE with all outputs cleared; fsm_clr stays 0 and the FSM relies on its own reset.
- x_out is 0 in every state except RUN.

Test Plan:
- Reset in RUN at step 2 -> all outputs 0 and state IDLE immediately, before the next clock edge.
- pat=8'h03, len=3, target=5 (x=1,1,0): S0->S1->S2->S5 -> y_log=8'h00, hit_cnt=0, final_state=5, match=1, done 5 cycles after start.
- pat=8'h00, len=2, target=5 (x=0,0): S0->S5->S5 -> y_log=8'h02, hit_cnt=1, final_state=5, match=1.
- pat=8'h09, len=5, target=7 (x=1,0,0,1,0): S0->S1->S3->S6->S7->S6 -> y_log=8'h1C, hit_cnt=3, final_state=6, match=0.
- start with len=0, then len=9 -> err pulses once per attempt, busy stays 0, prior results unchanged. start held during a run -> ignored, exactly one done.
- abort at 3rd RUN cycle of an 8-step run -> IDLE next edge, no done, match=0, y_log bits 0..2 valid. New start afterwards -> runs normally.

Source files
------------

// File: rtl/fsm_seq_ctrl.sv
// Sequencer for the 8-state x/y control FSM: clears it to S0, drives a latched
// x pattern one bit per clock, and logs the Mealy y response and final state.
module fsm_seq_ctrl #(
  parameter int LEN = 8,
  parameter int CW  = $clog2(LEN + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic [LEN-1:0] pat,
  input  logic [CW-1:0]  len,
  input  logic [2:0]     target,
  input  logic           y_in,
  input  logic [2:0]     state_in,
  output logic           x_out,
  output logic           fsm_clr,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [LEN-1:0] y_log,
  output logic [CW-1:0]  hit_cnt,
  output logic [2:0]     final_state,
  output logic           match
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

  localparam logic [CW-1:0] LEN_C   = CW'(LEN);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  logic [1:0]     seqState;
  logic [1:0]     seqNext;
  logic [IW-1:0]  stepIdx;
  logic [LEN-1:0] patLat;
  logic [CW-1:0]  lenLat;
  logic [2:0]     targetLat;

  logic lenOk;
  logic accept;
  logic lastStep;

  assign lenOk    = (len != '0) && (len <= LEN_C);
  assign accept   = (seqState == IDLE) && start && lenOk;
  assign lastStep = ((CW'(stepIdx) + ONE_C) == lenLat);

  // Control outputs are pure state decodes so an async reset clears them at once.
  assign busy    = (seqState != IDLE);
  assign fsm_clr = (seqState == CLEAR);
  assign done    = (seqState == DONE);
  assign x_out   = (seqState == RUN) ? patLat[stepIdx] : 1'b0;

  always_comb begin
    seqNext = seqState;
    case (seqState)
      IDLE:    if (accept) seqNext = CLEAR;
      CLEAR:   seqNext = abort ? IDLE : RUN;
      RUN: begin
        if (abort)         seqNext = IDLE;
        else if (lastStep) seqNext = DONE;
      end
      DONE:    seqNext = IDLE;
      default: seqNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seqState    <= IDLE;
      stepIdx     <= '0;
      err         <= 1'b0;
      y_log       <= '0;
      hit_cnt     <= '0;
      final_state <= 3'd0;
      match       <= 1'b0;
    end else begin
      seqState <= seqNext;
      err      <= (seqState == IDLE) && start && !lenOk;
      case (seqState)
        IDLE: begin
          if (accept) begin
            y_log   <= '0;
            hit_cnt <= '0;
            match   <= 1'b0;
          end
        end
        CLEAR: begin
          stepIdx <= '0;
          if (abort) match <= 1'b0;
        end
        RUN: begin
          // The step being aborted is still logged; y_in is valid for it.
          y_log[stepIdx] <= y_in;
          hit_cnt        <= hit_cnt + CW'(y_in);
          if (abort)          match   <= 1'b0;
          else if (!lastStep) stepIdx <= stepIdx + IDX_ONE;
        end
        DONE: begin
          final_state <= state_in;
          match       <= (state_in == targetLat);
        end
        default: ;
      endcase
    end
  end

  // Run parameters are pure data, captured only when a run is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      patLat    <= pat;
      lenLat    <= len;
      targetLat <= target;
    end
  end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Scoreboard bench for fsm_seq_ctrl with a behavioural 8-state x/y FSM attached.
module tb_fsm_seq_ctrl;

  localparam int LEN = 8;
  localparam int CW  = $clog2(LEN + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [LEN-1:0] pat = '0;
  logic [CW-1:0]  len = '0;
  logic [2:0]     target = 3'd0;
  logic           y_in;
  logic [2:0]     state_in;
  logic           x_out, fsm_clr, busy, done, err, match;
  logic [LEN-1:0] y_log;
  logic [CW-1:0]  hit_cnt;
  logic [2:0]     final_state;

  fsm_seq_ctrl #(.LEN(LEN), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pat(pat), .len(len),
    .target(target), .y_in(y_in), .state_in(state_in), .x_out(x_out),
    .fsm_clr(fsm_clr), .busy(busy), .done(done), .err(err), .y_log(y_log),
    .hit_cnt(hit_cnt), .final_state(final_state), .match(match)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] fsmNext(input logic [2:0] s, input logic x);
    case (s)
      3'd0:    return x ? 3'd1 : 3'd5;
      3'd1:    return x ? 3'd2 : 3'd3;
      3'd2:    return x ? 3'd4 : 3'd5;
      3'd3:    return x ? 3'd7 : 3'd6;
      3'd4:    return x ? 3'd2 : 3'd0;
      3'd5:    return x ? 3'd3 : 3'd5;
      3'd6:    return x ? 3'd7 : 3'd4;
      default: return x ? 3'd7 : 3'd6;
    endcase
  endfunction

  function automatic logic fsmY(input logic [2:0] s, input logic x);
    case (s)
      3'd3, 3'd4, 3'd5: return ~x;
      3'd6:             return x;
      3'd7:             return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  logic [2:0] fsmState;
  always @(posedge clk or negedge reset) begin
    if (!reset)       fsmState <= 3'd0;
    else if (fsm_clr) fsmState <= 3'd0;
    else              fsmState <= fsmNext(fsmState, x_out);
  end
  assign state_in = fsmState;
  assign y_in     = fsmY(fsmState, x_out);

  typedef struct {
    logic [LEN-1:0] ylog;
    logic [CW-1:0]  hits;
    logic [2:0]     fin;
    logic           mat;
    int             doneCyc;
  } exp_t;

  function automatic exp_t refRun(input logic [LEN-1:0] p, input int l, input logic [2:0] t);
    exp_t e;
    logic [2:0] s;
    logic yb;
    int h;
    s = 3'd0;
    h = 0;
    e.ylog = '0;
    for (int i = 0; i < l; i++) begin
      yb = fsmY(s, p[i]);
      e.ylog[i] = yb;
      h += int'(yb);
      s = fsmNext(s, p[i]);
    end
    e.hits = CW'(h);
    e.fin = s;
    e.mat = (s == t);
    e.doneCyc = 0;
    return e;
  endfunction

  function automatic exp_t mkExp(input logic [LEN-1:0] yl, input int h, input logic [2:0] f, input logic m);
    exp_t e;
    e.ylog = yl; e.hits = CW'(h); e.fin = f; e.mat = m; e.doneCyc = 0;
    return e;
  endfunction

  int   nTests = 0;
  int   nFail = 0;
  int   cyc = 0;
  int   doneCount = 0;
  exp_t expQ[$];
  int   errQ[$];
  exp_t lastExp;
  exp_t cur;
  logic pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nTests++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic checkHeld(input string nm, input exp_t e);
    chk({nm, "_ylog"},  32'(y_log),       32'(e.ylog));
    chk({nm, "_hits"},  32'(hit_cnt),     32'(e.hits));
    chk({nm, "_final"}, 32'(final_state), 32'(e.fin));
    chk({nm, "_match"}, 32'(match),       32'(e.mat));
  endtask

  // Monitor: pops the scoreboard on each done and checks the held results one cycle later.
  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      checkHeld("run", cur);
    end
    if (reset && done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        nTests++; nFail++;
        $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        cur = expQ.pop_front();
        chk("done_latency", 32'(cyc), 32'(cur.doneCyc));
        pend = 1'b1;
      end
    end
    if (reset && err) begin
      if (errQ.size() == 0) begin
        nTests++; nFail++;
        $display("FAIL unexpected_err: got err=1, expected no err (cycle %0d)", cyc);
      end else begin
        chk("err_cycle", 32'(cyc), 32'(errQ.pop_front()));
      end
    end
  end

  task automatic issueStart(input logic [LEN-1:0] p, input int l, input logic [2:0] t,
                            input int hold, input logic withAbort);
    exp_t e;
    @(posedge clk); #1;
    pat = p; len = CW'(l); target = t; start = 1'b1; abort = withAbort;
    if (l >= 1 && l <= LEN) begin
      e = refRun(p, l, t);
      e.doneCyc = cyc + l + 2;
      expQ.push_back(e);
      lastExp = e;
    end else begin
      errQ.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [LEN-1:0] p;
    logic [2:0] t, prevFin;
    int l, mode, dc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_xout", 32'(x_out), 0);
    checkHeld("rst", mkExp('0, 0, 3'd0, 1'b0));
    #2 reset = 1'b1;

    // Test-plan vectors
    issueStart(8'h03, 3, 3'd5, 0, 1'b0); waitIdle();
    checkHeld("vec1", mkExp(8'h00, 0, 3'd5, 1'b1));
    issueStart(8'h00, 2, 3'd5, 0, 1'b0); waitIdle();
    checkHeld("vec2", mkExp(8'h02, 1, 3'd5, 1'b1));
    issueStart(8'h09, 5, 3'd7, 0, 1'b0); waitIdle();
    checkHeld("vec3", mkExp(8'h1C, 3, 3'd6, 1'b0));

    // Illegal lengths
    issueStart(8'hFF, 0, 3'd1, 0, 1'b0);
    chk("err0_busy", 32'(busy), 0);
    checkHeld("err0_keep", mkExp(8'h1C, 3, 3'd6, 1'b0));
    issueStart(8'hFF, 9, 3'd1, 0, 1'b0);
    chk("err9_busy", 32'(busy), 0);
    checkHeld("err9_keep", mkExp(8'h1C, 3, 3'd6, 1'b0));

    // start held through a whole run
    issueStart(8'h03, 3, 3'd5, 4, 1'b0); waitIdle();

    // abort in the third RUN cycle of an 8-step run
    prevFin = lastExp.fin;
    @(posedge clk); #1;
    pat = 8'hA5; len = CW'(8); target = 3'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dc = doneCount;
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    e = refRun(8'hA5, 3, 3'd0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_xout", 32'(x_out), 0);
    checkHeld("abort", mkExp(e.ylog, int'(e.hits), prevFin, 1'b0));
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(doneCount - dc), 0);
    lastExp = mkExp(e.ylog, int'(e.hits), prevFin, 1'b0);

    e = refRun(8'h5A, 8, 3'd0);
    issueStart(8'h5A, 8, e.fin, 0, 1'b0); waitIdle();
    repeat (2) @(posedge clk);

    // Async reset during RUN step 2
    issueStart(8'h00, 8, 3'd0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("midrun_ylog", 32'(y_log), 32'h02);
    reset = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_err", 32'(err), 0);
    chk("mrst_xout", 32'(x_out), 0);
    chk("mrst_clr", 32'(fsm_clr), 0);
    checkHeld("mrst", mkExp('0, 0, 3'd0, 1'b0));
    expQ.delete();
    errQ.delete();
    lastExp = mkExp('0, 0, 3'd0, 1'b0);
    #3 reset = 1'b1;

    // Randomized runs
    for (int n = 0; n < 60; n++) begin
      p = LEN'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        l = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(LEN + 1, 15);
        issueStart(p, l, 3'($urandom_range(0, 7)), 0, 1'b0);
        chk("rnd_err_busy", 32'(busy), 0);
        checkHeld("rnd_err_keep", lastExp);
      end else begin
        l = $urandom_range(1, LEN);
        e = refRun(p, l, 3'd0);
        t = ($urandom_range(0, 1) == 1) ? e.fin : 3'($urandom_range(0, 7));
        mode = $urandom_range(0, 3);
        case (mode)
          1: issueStart(p, l, t, 0, 1'b1);
          2: issueStart(p, l, t, $urandom_range(1, l + 1), 1'b0);
          3: begin
            issueStart(p, l, t, 0, 1'b0);
            repeat (l + 1) @(posedge clk);
            #1; abort = 1'b1;
            @(posedge clk); #1; abort = 1'b0;
          end
          default: issueStart(p, l, t, 0, 1'b0);
        endcase
        waitIdle();
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("pending_done", 32'(expQ.size()), 0);
    chk("pending_err", 32'(errQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
